sys_bridge: RTL and testbench

SYS_BRIDGE -- requirements
Module: sys_bridge

---
 rtl/bridge_pkg.sv | 50 +++++
 rtl/tc_unit.sv | 105 ++++++++++
 rtl/sys_bridge.sv | 72 +++++++
 tb/tb_sys_bridge.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the system bridge: register map, CTRL fields, timer modes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bridge_pkg;

  // Word offsets inside a 16-byte timer window (PrAddr[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  // MODE encodings; 2'b1x behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  function automatic logic is_auto(input logic [1:0] mode);
    return mode == MODE_AUTO;
  endfunction

  // Read view of one timer window; reserved offset reads as zero
  function automatic logic [31:0] tc_read(input logic [1:0]        off,
                                          input logic [CTRL_W-1:0] ctrl,
                                          input logic [31:0]       preset,
                                          input logic [31:0]       count);
    logic [31:0] r;
    r = 32'h0;
    case (off)
      OFF_CTRL:   r = {{(32-CTRL_W){1'b0}}, ctrl};
      OFF_PRESET: r = preset;
      OFF_COUNT:  r = count;
      default:    r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tc_unit.sv
// One down-counting timer: CTRL/PRESET/COUNT registers, IDLE/LOAD/CNT/INT FSM and IRQ flag.
// Latency: register writes and FSM steps take effect on the next rising edge.
// Backpressure: none; a qualified write is always accepted.
module tc_unit
  import bridge_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_off,
  input  logic [31:0]       wr_dat,
  output logic [CTRL_W-1:0] ctrl,
  output logic [31:0]       preset,
  output logic [31:0]       count,
  output logic              irq
);

  tc_state_e         state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic              flag_q, flag_d;

  logic       en;
  logic [1:0] mode;

  assign en   = ctrl_q[CTRL_EN];
  assign mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

  // State and register storage; reset aborts any count in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= TC_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state: FSM first, then bus writes override (a CTRL write beats the one-shot EN clear)
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      TC_IDLE: begin
        if (en) state_d = TC_LOAD;
      end
      TC_LOAD: begin
        count_d = preset_q;
        state_d = TC_CNT;
      end
      TC_CNT: begin
        if (!en) begin
          state_d = TC_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers PRESET=0 as well: clamp at zero rather than wrapping
          count_d = 32'd0;
          flag_d  = 1'b1;
          state_d = TC_INT;
        end
      end
      TC_INT: begin
        if (is_auto(mode)) begin
          // Auto-reload: flag is visible only during this INT cycle
          flag_d  = 1'b0;
          state_d = TC_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = TC_IDLE;
        end
      end
      default: state_d = TC_IDLE;
    endcase

    if (wr_en) begin
      case (wr_off)
        OFF_CTRL: begin
          ctrl_d = wr_dat[CTRL_W-1:0];
          flag_d = 1'b0;
        end
        OFF_PRESET: preset_d = wr_dat;
        default: ;
      endcase
    end
  end

  assign ctrl   = ctrl_q;
  assign preset = preset_q;
  assign count  = count_q;
  assign irq    = flag_q & ctrl_q[CTRL_IM];

endmodule

// File: rtl/sys_bridge.sv
// CPU-to-device bridge: decodes two timer windows, muxes read data, assembles the CP0 interrupt vector.
// Latency: reads are combinational (zero cycles); writes commit on the next rising edge.
// Backpressure: none; every access completes in its own cycle.
module sys_bridge
  import bridge_pkg::*;
#(
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        PrWE,
  input  logic [3:0]  PrBE,
  input  logic [3:0]  ExtIrq,
  output logic [31:0] PrRD,
  output logic [5:0]  HWInt
);

  logic              hit0, hit1;
  logic              wr_full;
  logic [1:0]        off;
  logic [CTRL_W-1:0] ctrl0, ctrl1;
  logic [31:0]       preset0, preset1;
  logic [31:0]       count0, count1;
  logic              irq0, irq1;
  logic              addr_lsb_unused;

  assign hit0    = (PrAddr[31:4] == TC0_BASE[31:4]);
  assign hit1    = (PrAddr[31:4] == TC1_BASE[31:4]);
  assign off     = PrAddr[3:2];
  // Only full-word stores reach the timers; partial stores are dropped
  assign wr_full = PrWE && (PrBE == 4'b1111);
  // Registers are word-wide; the byte offset within a word carries no meaning here
  assign addr_lsb_unused = ^PrAddr[1:0];

  tc_unit u_tc0 (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_full && hit0),
    .wr_off (off),
    .wr_dat (PrWD),
    .ctrl   (ctrl0),
    .preset (preset0),
    .count  (count0),
    .irq    (irq0)
  );

  tc_unit u_tc1 (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_full && hit1),
    .wr_off (off),
    .wr_dat (PrWD),
    .ctrl   (ctrl1),
    .preset (preset1),
    .count  (count1),
    .irq    (irq1)
  );

  // Read mux: unmapped addresses return zero
  always_comb begin
    PrRD = 32'h0;
    if (hit0)      PrRD = tc_read(off, ctrl0, preset0, count0);
    else if (hit1) PrRD = tc_read(off, ctrl1, preset1, count1);
  end

  // External lines bypass all registers
  assign HWInt = {ExtIrq, irq1, irq0};

endmodule

// File: tb/tb_sys_bridge.sv
module tb_sys_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic [3:0]  PrBE;
  logic [3:0]  ExtIrq;
  logic [31:0] PrRD;
  logic [5:0]  HWInt;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] T0_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] T0_PRESET = 32'h0000_7F04;
  localparam logic [31:0] T0_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] T0_RSVD   = 32'h0000_7F0C;
  localparam logic [31:0] T1_CTRL   = 32'h0000_7F10;
  localparam logic [31:0] T1_PRESET = 32'h0000_7F14;
  localparam logic [31:0] T1_COUNT  = 32'h0000_7F18;

  sys_bridge dut (
    .clk    (clk),
    .reset  (reset),
    .PrAddr (PrAddr),
    .PrWD   (PrWD),
    .PrWE   (PrWE),
    .PrBE   (PrBE),
    .ExtIrq (ExtIrq),
    .PrRD   (PrRD),
    .HWInt  (HWInt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive a store from a negedge; it commits on the following rising edge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    PrAddr = a;
    PrWD   = d;
    PrBE   = be;
    PrWE   = 1'b1;
    @(negedge clk);
    PrWE   = 1'b0;
    PrBE   = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    PrAddr = a;
    #1;
    chk(tag, PrRD, exp);
  endtask

  task automatic hw_chk(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, HWInt}, {26'd0, exp});
  endtask

  initial begin
    reset  = 1'b0;
    PrAddr = 32'h0;
    PrWD   = 32'h0;
    PrWE   = 1'b0;
    PrBE   = 4'h0;
    ExtIrq = 4'h0;

    // Reset state
    @(negedge clk);
    rd_chk("rst_ctrl0", T0_CTRL, 32'h0);
    rd_chk("rst_preset1", T1_PRESET, 32'h0);
    rd_chk("rst_count0", T0_COUNT, 32'h0);
    hw_chk("rst_hwint", 6'b000000);
    reset = 1'b1;
    @(negedge clk);

    // External interrupts pass straight through
    ExtIrq = 4'b1010;
    hw_chk("ext_pass", 6'b101000);
    ExtIrq = 4'b0000;
    hw_chk("ext_clear", 6'b000000);

    // Partial byte enables, COUNT write, unmapped and reserved reads
    bus_wr(T0_CTRL, 32'h9, 4'b0011);
    rd_chk("be_partial", T0_CTRL, 32'h0);
    bus_wr(T0_COUNT, 32'h55, 4'b1111);
    rd_chk("count_ro", T0_COUNT, 32'h0);
    bus_wr(T0_RSVD, 32'hDEAD_BEEF, 4'b1111);
    rd_chk("rsvd_zero", T0_RSVD, 32'h0);
    rd_chk("nohit_zero", 32'h0000_3000, 32'h0);

    // One-shot with IRQ enabled: PRESET=5
    bus_wr(T0_PRESET, 32'd5, 4'b1111);
    rd_chk("preset_rb", T0_PRESET, 32'd5);
    bus_wr(T0_CTRL, 32'h9, 4'b1111);
    @(negedge clk);               // LOAD
    @(negedge clk);               // first CNT
    rd_chk("os_cnt5", T0_COUNT, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      rd_chk($sformatf("os_cnt%0d", 5 - i), T0_COUNT, 32'(5 - i));
      hw_chk($sformatf("os_irq%0d", i), (i == 5) ? 6'b000001 : 6'b000000);
    end
    @(negedge clk);
    rd_chk("os_en_clr", T0_CTRL, 32'h8);
    hw_chk("os_irq_hold", 6'b000001);
    @(negedge clk);
    hw_chk("os_irq_hold2", 6'b000001);
    bus_wr(T0_CTRL, 32'h0, 4'b1111);
    hw_chk("os_irq_clr", 6'b000000);

    // PRESET=0: LOAD, CNT, INT back to back
    bus_wr(T0_PRESET, 32'd0, 4'b1111);
    bus_wr(T0_CTRL, 32'h9, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    rd_chk("p0_cnt", T0_COUNT, 32'd0);
    hw_chk("p0_noirq", 6'b000000);
    @(negedge clk);
    rd_chk("p0_nowrap", T0_COUNT, 32'd0);
    hw_chk("p0_irq", 6'b000001);
    bus_wr(T0_CTRL, 32'h0, 4'b1111);

    // Auto-reload on timer 1: one-cycle pulse every 5 cycles
    bus_wr(T1_PRESET, 32'd3, 4'b1111);
    bus_wr(T1_CTRL, 32'hB, 4'b1111);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      hw_chk($sformatf("ar_c%0d", i), (i % 5 == 0) ? 6'b000010 : 6'b000000);
    end
    rd_chk("ar_en_kept", T1_CTRL, 32'hB);
    bus_wr(T1_CTRL, 32'h0, 4'b1111);

    // Masked IRQ, then CTRL write clears the latched flag
    bus_wr(T0_PRESET, 32'd10, 4'b1111);
    bus_wr(T0_CTRL, 32'h1, 4'b1111);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      hw_chk($sformatf("mask_c%0d", i), 6'b000000);
    end
    rd_chk("mask_done_cnt", T0_COUNT, 32'd0);
    rd_chk("mask_en_clr", T0_CTRL, 32'h0);
    bus_wr(T0_CTRL, 32'h8, 4'b1111);
    hw_chk("mask_flag_clr", 6'b000000);
    rd_chk("mask_ctrl8", T0_CTRL, 32'h8);

    // PRESET rewrite mid-count only lands on next LOAD; EN=0 holds COUNT
    bus_wr(T0_PRESET, 32'd6, 4'b1111);
    bus_wr(T0_CTRL, 32'h1, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    rd_chk("pw_cnt6", T0_COUNT, 32'd6);
    bus_wr(T0_PRESET, 32'd2, 4'b1111);
    rd_chk("pw_cnt5", T0_COUNT, 32'd5);
    rd_chk("pw_preset2", T0_PRESET, 32'd2);
    @(negedge clk);
    rd_chk("pw_cnt4", T0_COUNT, 32'd4);
    bus_wr(T0_CTRL, 32'h0, 4'b1111);
    rd_chk("pw_stop3", T0_COUNT, 32'd3);
    @(negedge clk);
    @(negedge clk);
    rd_chk("pw_hold3", T0_COUNT, 32'd3);
    bus_wr(T0_CTRL, 32'h1, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    rd_chk("pw_reload2", T0_COUNT, 32'd2);
    bus_wr(T0_CTRL, 32'h0, 4'b1111);

    // Asynchronous reset mid-count
    bus_wr(T0_PRESET, 32'd10, 4'b1111);
    bus_wr(T0_CTRL, 32'h9, 4'b1111);
    repeat (5) @(negedge clk);
    rd_chk("ar_cnt7", T0_COUNT, 32'd7);
    ExtIrq = 4'b0110;
    #1;
    reset = 1'b0;
    rd_chk("arst_count", T0_COUNT, 32'd0);
    rd_chk("arst_ctrl", T0_CTRL, 32'h0);
    rd_chk("arst_preset", T0_PRESET, 32'h0);
    rd_chk("arst_t1cnt", T1_COUNT, 32'h0);
    hw_chk("arst_hwint", 6'b011000);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    hw_chk("arst_noirq", 6'b011000);
    rd_chk("arst_idle_cnt", T0_COUNT, 32'd0);
    ExtIrq = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
